// File: rtl/score_collector.sv
// score_collector: collects new per-lane ScoreBank results (one report per
// distinct ID while vld is held), arbitrates them round-robin into a
// first-word-fall-through FIFO, and presents one {id, score} valid/ready stream.
// Optional build macro SCORE_UNBIAS_EN: out_score is reported relative to ZERO
// (two's complement) instead of as the raw biased lane score.

// One lane: new-result detect against last cycle's {vld, id}, plus a 1-deep slot.
module score_lane #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   vld,
    input  logic [ID_WIDTH-1:0]    id,
    input  logic [SCORE_WIDTH-1:0] score,
    input  logic                   drain,
    output logic                   full,
    output logic [ID_WIDTH-1:0]    slot_id,
    output logic [SCORE_WIDTH-1:0] slot_score,
    output logic                   drop
);
    logic                prev_vld;
    logic [ID_WIDTH-1:0] prev_id;
    logic                new_res;

    // A result is new on a vld rise or when the ID changes under a held vld.
    assign new_res = vld & (~prev_vld | (id != prev_id));
    // A new result arriving while the slot stays occupied is lost.
    assign drop    = new_res & full & ~drain;

    // History of last cycle's lane inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_vld <= 1'b0;
            prev_id  <= '0;
        end else if (clear) begin
            prev_vld <= 1'b0;
            prev_id  <= '0;
        end else begin
            prev_vld <= vld;
            prev_id  <= id;
        end
    end

    // Pending slot: capture when empty or being drained this same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full       <= 1'b0;
            slot_id    <= '0;
            slot_score <= '0;
        end else if (clear) begin
            full       <= 1'b0;
            slot_id    <= '0;
            slot_score <= '0;
        end else if (new_res && (!full || drain)) begin
            full       <= 1'b1;
            slot_id    <= id;
            slot_score <= score;
        end else if (drain) begin
            full       <= 1'b0;
        end
    end
endmodule

module score_collector #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48,
    parameter int MODULES     = 2,
    parameter int ZERO        = 2048,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [2*MODULES*SCORE_WIDTH-1:0]     results,
    input  logic [2*MODULES*ID_WIDTH-1:0]        IDs,
    input  logic [2*MODULES-1:0]                 vld,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ID_WIDTH-1:0]                  out_id,
    output logic [SCORE_WIDTH-1:0]               out_score,
    output logic [$clog2(FIFO_DEPTH):0]          count,
    output logic                                 overflow
);
    localparam int LANES = 2 * MODULES;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    logic [LANES-1:0]                  lane_full, lane_drop, drain;
    logic [LANES-1:0][ID_WIDTH-1:0]    lane_id;
    logic [LANES-1:0][SCORE_WIDTH-1:0] lane_sc;

    logic [LW-1:0] rr, grant, rr_next;
    logic          grant_vld, push, pop, can_push;

    logic [ID_WIDTH-1:0]    mem_id [FIFO_DEPTH];
    logic [SCORE_WIDTH-1:0] mem_sc [FIFO_DEPTH];
    logic [AW-1:0]          wptr, rptr;

    // Lane 0 occupies the MSB end of the packed results/IDs buses.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        score_lane #(.SCORE_WIDTH(SCORE_WIDTH), .ID_WIDTH(ID_WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .vld       (vld[g]),
            .id        (IDs[(LANES-1-g)*ID_WIDTH +: ID_WIDTH]),
            .score     (results[(LANES-1-g)*SCORE_WIDTH +: SCORE_WIDTH]),
            .drain     (drain[g]),
            .full      (lane_full[g]),
            .slot_id   (lane_id[g]),
            .slot_score(lane_sc[g]),
            .drop      (lane_drop[g])
        );
    end

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign can_push  = (count != CW'(FIFO_DEPTH)) | pop;
    assign push      = grant_vld & can_push;

    // Round-robin pick: first full slot at or after rr; scan backwards so the
    // smallest offset wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= LANES) idx = idx - LANES;
            if (lane_full[idx]) begin
                grant_vld = 1'b1;
                grant     = LW'(idx);
            end
        end
        rr_next = (int'(grant) == LANES - 1) ? '0 : grant + LW'(1);
        drain   = '0;
        if (push) drain[grant] = 1'b1;
    end

    // Round-robin pointer advances past each granted lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rr <= '0;
        else if (clear) rr <= '0;
        else if (push)  rr <= rr_next;
    end

    // FIFO storage; contents are don't-care until count marks them valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_id[wptr] <= lane_id[grant];
            mem_sc[wptr] <= lane_sc[grant];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             overflow <= 1'b0;
        else if (clear)       overflow <= 1'b0;
        else if (|lane_drop)  overflow <= 1'b1;
    end

    assign out_id = out_valid ? mem_id[rptr] : '0;
`ifdef SCORE_UNBIAS_EN
    assign out_score = out_valid ? (mem_sc[rptr] - SCORE_WIDTH'(ZERO)) : '0;
`else
    assign out_score = out_valid ? mem_sc[rptr] : '0;
`endif
endmodule

// File: tb/tb_score_collector.sv
// Directed bench for score_collector (MODULES=2, 4 lanes, FIFO_DEPTH=8).
module tb_score_collector;
    localparam int SW = 12;
    localparam int IW = 48;
    localparam int L  = 4;

    logic            clk = 1'b0;
    logic            rst, clear, out_ready;
    logic [L*SW-1:0] results;
    logic [L*IW-1:0] IDs;
    logic [L-1:0]    vld;
    logic            out_valid, overflow;
    logic [IW-1:0]   out_id;
    logic [SW-1:0]   out_score;
    logic [3:0]      count;

    int errors = 0;
    int checks = 0;
    logic [IW-1:0] q_id [$];
    logic [SW-1:0] q_sc [$];

    score_collector dut (
        .clk(clk), .rst(rst), .clear(clear), .results(results), .IDs(IDs),
        .vld(vld), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_score(out_score), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] exp_sc(input logic [SW-1:0] raw);
`ifdef SCORE_UNBIAS_EN
        return raw - 12'd2048;
`else
        return raw;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int j, input logic v, input logic [IW-1:0] id,
                            input logic [SW-1:0] sc);
        vld[j] = v;
        IDs[(L-1-j)*IW +: IW] = id;
        results[(L-1-j)*SW +: SW] = sc;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Records each head accepted at the next edge, for n cycles.
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (out_valid && out_ready) begin
                q_id.push_back(out_id);
                q_sc.push_back(out_score);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; clear = 1'b0; out_ready = 1'b0;
        vld = '0; IDs = '0; results = '0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || out_id !== '0 || out_score !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b c=%0d o=%b id=%0d sc=%0d exp all zero",
                     out_valid, count, overflow, out_id, out_score);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc=%0d got v=%b c=%0d o=%b exp 0/0/0", i, out_valid, count, overflow);
            end
        end
    endtask

    task automatic test_single_hold();
        out_ready = 1'b1;
        set_lane(1, 1'b1, 48'd7, 12'd2083);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_lat_e0 got v=%b exp 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 48'd7 || out_score !== exp_sc(12'd2083)) begin
            errors++;
            $display("FAIL hold_lat_e1 got v=%b id=%0d sc=%h exp v=1 id=7 sc=%h",
                     out_valid, out_id, out_score, exp_sc(12'd2083));
        end
        q_id.delete(); q_sc.delete();
        collect(8);
        set_lane(1, 1'b0, 48'd7, 12'd2083);
        collect(6);
        checks++;
        if (q_id.size() !== 1) begin
            errors++; $display("FAIL hold_beats got %0d exp 1", q_id.size());
        end
    endtask

    task automatic test_simultaneous();
        logic [SW-1:0] sc [4];
        sc[0] = 12'd2148; sc[1] = 12'd2248; sc[2] = 12'd2049; sc[3] = 12'd2045;
        do_clear();
        out_ready = 1'b1;
        for (int j = 0; j < L; j++) set_lane(j, 1'b1, 48'(j + 1), sc[j]);
        tick();
        vld = '0;
        tick();
        for (int c = 0; c < L; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_id !== 48'(c + 1) || out_score !== exp_sc(sc[c])) begin
                errors++;
                $display("FAIL simul_beat%0d got v=%b id=%0d sc=%h exp v=1 id=%0d sc=%h",
                         c, out_valid, out_id, out_score, c + 1, exp_sc(sc[c]));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL simul_end got v=%b exp 0", out_valid);
        end
        // Pointer back at lane 0: lane 0 must win over lane 1.
        set_lane(0, 1'b1, 48'd9, 12'd2050);
        set_lane(1, 1'b1, 48'd8, 12'd2051);
        tick();
        vld = '0;
        tick();
        checks++;
        if (out_id !== 48'd9) begin
            errors++; $display("FAIL rr_wrap_first got id=%0d exp 9", out_id);
        end
        tick();
        checks++;
        if (out_id !== 48'd8) begin
            errors++; $display("FAIL rr_wrap_second got id=%0d exp 8", out_id);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_clear();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_lane(0, 1'b1, 48'(10 + k), 12'(2048 + k));
            tick();
            if (k == 8) begin
                checks++;
                if (count !== 4'd8 || overflow !== 1'b0) begin
                    errors++; $display("FAIL bp_full got c=%0d o=%b exp c=8 o=0", count, overflow);
                end
            end
            if (k == 9) begin
                checks++;
                if (count !== 4'd8 || overflow !== 1'b1) begin
                    errors++; $display("FAIL bp_overflow got c=%0d o=%b exp c=8 o=1", count, overflow);
                end
            end
        end
        vld = '0;
        out_ready = 1'b1;
        q_id.delete(); q_sc.delete();
        collect(14);
        checks++;
        if (q_id.size() !== 9) begin
            errors++; $display("FAIL bp_drain_cnt got %0d exp 9", q_id.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (q_id[i] !== 48'(10 + i) || q_sc[i] !== exp_sc(12'(2048 + i))) begin
                    errors++;
                    $display("FAIL bp_drain%0d got id=%0d sc=%h exp id=%0d sc=%h",
                             i, q_id[i], q_sc[i], 10 + i, exp_sc(12'(2048 + i)));
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || count !== 4'd0) begin
            errors++; $display("FAIL bp_after got o=%b c=%0d exp o=1 c=0", overflow, count);
        end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_lane(0, 1'b1, 48'(20 + k), 12'(2060 + k));
            tick();
        end
        checks++;
        if (count !== 4'd3) begin
            errors++; $display("FAIL clr_pre got c=%0d exp 3", count);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_state got c=%0d v=%b o=%b exp 0/0/0", count, out_valid, overflow);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 48'd23) begin
            errors++; $display("FAIL clr_rereport got v=%b id=%0d exp v=1 id=23", out_valid, out_id);
        end
        out_ready = 1'b1;
        q_id.delete(); q_sc.delete();
        collect(8);
        checks++;
        if (q_id.size() !== 1) begin
            errors++; $display("FAIL clr_once got %0d beats exp 1", q_id.size());
        end
        vld = '0;
        tick();
    endtask

    task automatic test_id_change();
        out_ready = 1'b1;
        q_id.delete(); q_sc.delete();
        set_lane(2, 1'b1, 48'd5, 12'd2053);
        collect(3);
        set_lane(2, 1'b1, 48'd6, 12'd2054);
        collect(3);
        set_lane(2, 1'b0, 48'd6, 12'd2054);
        collect(6);
        checks++;
        if (q_id.size() !== 2) begin
            errors++; $display("FAIL idchg_cnt got %0d exp 2", q_id.size());
        end else begin
            checks++;
            if (q_id[0] !== 48'd5 || q_id[1] !== 48'd6 || q_sc[1] !== exp_sc(12'd2054)) begin
                errors++;
                $display("FAIL idchg_order got %0d,%0d sc=%h exp 5,6 sc=%h",
                         q_id[0], q_id[1], q_sc[1], exp_sc(12'd2054));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_simultaneous();
        test_backpressure();
        test_clear();
        test_id_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/score_collector.md
Name: score_collector

Overview:
- Sits directly downstream of ScoreBank_v1 and consumes its per-lane `results`/`IDs`/`vld` outputs (2*MODULES lanes).
- Detects each new result once per lane, even though a lane holds `vld` high across cycles.
- Arbitrates new results round-robin into a FIFO and presents them as one {id, score} valid/ready stream for the host/readback logic.

Parameters:
SCORE_WIDTH, 12, width of one lane score (biased)
ID_WIDTH, 48, width of one lane sequence ID
MODULES, 2, scoring modules per bank; lanes = 2*MODULES
ZERO, 2048, biased zero of scores (2**(SCORE_WIDTH-1))
FIFO_DEPTH, 8, output FIFO entries, power of two, >=2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
clear  in  1  sync: flush FIFO, pending slots, overflow, history
results  in  2*MODULES*SCORE_WIDTH  lane scores, lane 0 at MSB end (index 0)
IDs  in  2*MODULES*ID_WIDTH  lane IDs, same packing
vld  in  2*MODULES  lane valid, bit 0 = lane 0
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head when out_valid&out_ready
out_id  out  ID_WIDTH  head ID
out_score  out  SCORE_WIDTH  head score (see Optional Feature)
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a lane result was dropped

Behaviour:
- Reset (rst=0, async): out_valid=0, out_id=0, out_score=0, count=0, overflow=0; pending slots empty; per-lane prev_vld=0, prev_id=0; RR pointer=lane 0.
- clear=1 at an edge: same state as reset, synchronous; clear has priority over every other action in that cycle.
- New-result detect, per lane j, each edge: new_j = vld[j] & (~prev_vld[j] | IDs_j != prev_id[j]). Then prev_vld[j]<=vld[j], prev_id[j]<=IDs_j.
- Pending slot per lane, 1 deep, holding {id, score}:
  - new_j & slot empty -> capture.
  - new_j & slot full & not drained this cycle -> drop the new result, set overflow.
  - new_j & slot drained this same edge -> capture the new one, no overflow.
- Arbiter: each edge, if FIFO not full or being popped, grant the first full slot at or after the RR pointer (wrapping). Write it to the FIFO, empty the slot, set the pointer to grant+1 mod lanes. At most one write per cycle.
- FIFO: circular buffer, first-word-fall-through.
  - out_valid = count != 0; out_id/out_score = head entry.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are allowed when full (count unchanged) and when empty is not applicable: a push is never visible on the same edge.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: vld rising sampled at edge E0 -> slot full after E0 -> FIFO write at E1 (if granted, FIFO not full) -> out_valid=1 after E1. Minimum 2 edges.
- Backpressure: out_ready=0 with FIFO full stalls the arbiter; slots hold; further new results on full-slot lanes set overflow.
- Lane ordering preserved per lane; cross-lane order follows RR grant.
- vld held high with constant ID: exactly one entry. vld held high while ID changes: one entry per distinct ID.

Optional Feature:
SCORE_UNBIAS_EN
- Defined: out_score = stored score - ZERO, two's-complement, SCORE_WIDTH bits (e.g. biased 2048+35 -> 35; 2048-3 -> 0xFFD).
- Undefined: out_score is the raw biased lane score.
- Storage and all other behaviour are identical either way.

Test Plan:
- Reset/idle: rst=0 for 3 cycles then 1, vld=0 -> out_valid=0, count=0, overflow=0 for 20 cycles.
- Single hold:
  - Stimulus: lane 1 vld=1, ID=7, score=2048+35, held for 10 cycles; out_ready=1.
  - Response: exactly one beat {7, 2083}, or {7, 35} with SCORE_UNBIAS_EN; out_valid rises 2 edges after vld is sampled.
- Simultaneous lanes:
  - Stimulus: all 4 lanes (MODULES=2) assert new IDs 1..4 on the same edge; out_ready=1.
  - Response: beats arrive in lane order 0,1,2,3 on consecutive cycles; RR pointer ends at 0.
- Backpressure/overflow:
  - Stimulus: out_ready=0; lane 0 issues IDs 10..19 back-to-back, one per cycle.
  - Response: count saturates at 8; slot holds one more; overflow=1 from the first further new ID.
  - Then out_ready=1: IDs 10..18 drain in order, and overflow stays 1.
- ID change under held vld: lane 2 vld=1 with ID 5 for 3 cycles, then ID 6 for 3 cycles -> exactly two beats, {5} then {6}.
- Clear mid-operation: FIFO holding 3 entries and 1 slot full, clear=1 for 1 cycle -> next cycle count=0, out_valid=0, overflow=0; a held vld with an unchanged ID re-reports once afterwards (history cleared).
